// File: rtl/fifo_native2stream_pkg.sv
// Shared definitions for the native-FIFO to AXI-Stream read adapter.
package fifo_native2stream_pkg;

  localparam int DATA_WIDTH_DEF  = 256;
  localparam int FIFO_RD_LATENCY = 1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } buf_state_e;

  // Words held in the output buffer plus the word still in flight from the FIFO.
  function automatic logic [2:0] occupancy(input logic [1:0] level, input logic pend);
    return {1'b0, level} + {2'b00, pend};
  endfunction

endpackage

// File: rtl/fifo_native2stream_if.sv
// FIFO read port and AXI-Stream master signals of the read adapter.
interface fifo_native2stream_if
  import fifo_native2stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  m_axis_tvalid;
  logic                  m_axis_tready;
  logic [DATA_WIDTH-1:0] m_axis_tdata;
  logic [1:0]            buf_level;

  modport master (
    output rd_en, m_axis_tvalid, m_axis_tdata, buf_level,
    input  data_out, empty, m_axis_tready
  );

  modport slave (
    input  rd_en, m_axis_tvalid, m_axis_tdata, buf_level,
    output data_out, empty, m_axis_tready
  );
endinterface

// File: rtl/fifo_native2stream_skid.sv
// Two-entry head/skid output buffer; head drives the stream data directly.
//   state    | meaning
//   ST_EMPTY | no word held, tvalid low
//   ST_ONE   | head holds the next word, skid free
//   ST_FULL  | head and skid both hold words, skid is the younger one
module axis_out_skid2
  import fifo_native2stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  valid,
  output logic [1:0]            level
);

  buf_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] head, skid;
  logic                  ld_head_din, ld_head_skid, ld_skid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_EMPTY;
      head  <= '0;
      skid  <= '0;
    end else begin
      state <= state_nxt;
      if (ld_head_din)
        head <= din;
      else if (ld_head_skid)
        head <= skid;
      if (ld_skid)
        skid <= din;
    end
  end

  always_comb begin
    state_nxt    = state;
    ld_head_din  = 1'b0;
    ld_head_skid = 1'b0;
    ld_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (push) begin
          ld_head_din = 1'b1;
          state_nxt   = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          ld_skid   = 1'b1;
          state_nxt = ST_FULL;
        end else if (push && pop) begin
          ld_head_din = 1'b1;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          ld_head_skid = 1'b1;
          if (push)
            ld_skid = 1'b1;
          else
            state_nxt = ST_ONE;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  assign dout  = head;
  assign valid = (state != ST_EMPTY);
  assign level = state;

  // The read credit rule upstream must never deliver a third word.
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(state == ST_FULL && push && !pop));

endmodule

// File: rtl/fifo_native2stream.sv
// Drains a native FIFO (1-cycle read latency) onto an AXI-Stream master port.
module fifo_native2stream
  import fifo_native2stream_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_native2stream_if.master bus
);

  logic       rd_pend;
  logic       pop;
  logic       push;
  logic [1:0] level;
  logic [2:0] occ;

  assign pop  = bus.m_axis_tvalid & bus.m_axis_tready;
  assign push = rd_pend;
  assign occ  = occupancy(level, rd_pend);

  // Only issue a read when the buffer is guaranteed a free slot for it.
  assign bus.rd_en = !bus.empty && !rst &&
                     ((occ <= 3'd1) || ((occ == 3'd2) && pop));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_pend <= 1'b0;
    else
      rd_pend <= bus.rd_en;
  end

  axis_out_skid2 #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (bus.data_out),
    .dout  (bus.m_axis_tdata),
    .valid (bus.m_axis_tvalid),
    .level (level)
  );

  assign bus.buf_level = level;

  a_rd_latency: assert property (@(posedge clk) disable iff (rst)
    bus.rd_en |-> ##FIFO_RD_LATENCY rd_pend);

endmodule

// File: tb/tb_fifo_native2stream.sv
// Scoreboard bench: a queue-based FIFO model feeds the adapter, a monitor checks stream order.
module tb_fifo_native2stream;
  import fifo_native2stream_pkg::*;

  localparam int DW = 256;
  typedef logic [DW-1:0] word_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fifo_native2stream_if #(.DATA_WIDTH(DW)) bus ();

  fifo_native2stream #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  word_t fifo_q[$];
  word_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    gap_pct  = 0;

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < DW / 32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load(input word_t w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic at_tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (3) at_tick();
  endtask

  // Native FIFO model: data of a read appears on data_out the cycle after rd_en.
  initial begin
    bit    take;
    word_t w;
    bus.empty    = 1'b1;
    bus.data_out = '0;
    forever begin
      @(negedge clk);
      take = bus.rd_en;
      check("rd_en_gated_by_empty", word_t'(take & bus.empty), 0);
      if (take && fifo_q.size() > 0) w = fifo_q.pop_front();
      else w = rand_word();
      @(posedge clk);
      #1;
      bus.data_out = take ? w : rand_word();
      bus.empty    = (fifo_q.size() == 0) || ($urandom_range(99) < gap_pct);
    end
  end

  // Stream monitor / scoreboard.
  initial begin
    bit    prev_stall = 1'b0;
    word_t prev_data  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        continue;
      end
      check("buf_level_le_2", word_t'(bus.buf_level <= 2'd2), 1);
      check("tvalid_vs_level", bus.m_axis_tvalid, word_t'(bus.buf_level != 2'd0));
      if (prev_stall) begin
        check("stall_tvalid_hold", bus.m_axis_tvalid, 1);
        check("stall_tdata_hold", bus.m_axis_tdata, prev_data);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", bus.m_axis_tdata, 'x);
        else check("beat_data", bus.m_axis_tdata, exp_q.pop_front());
      end
      prev_stall = bus.m_axis_tvalid && !bus.m_axis_tready;
      prev_data  = bus.m_axis_tdata;
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_first, rd_last, rd_cnt, bt_first, bt_last, bt_cnt, n;
    rst = 1'b1;
    bus.m_axis_tready = 1'b0;

    // Reset and idle
    repeat (3) begin
      @(negedge clk);
      check("rst_tvalid", bus.m_axis_tvalid, 0);
      check("rst_level", bus.buf_level, 0);
      check("rst_rd_en", bus.rd_en, 0);
    end
    at_tick();
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_rd_en", bus.rd_en, 0);
      check("idle_tvalid", bus.m_axis_tvalid, 0);
      check("idle_tdata", bus.m_axis_tdata, 0);
      check("idle_level", bus.buf_level, 0);
    end

    // Single word latency
    at_tick();
    bus.m_axis_tready = 1'b1;
    load(word_t'(8'hA5));
    @(negedge clk);
    @(negedge clk);
    check("single_rd_en_c0", bus.rd_en, 1);
    @(negedge clk);
    check("single_tvalid_c1", bus.m_axis_tvalid, 0);
    @(negedge clk);
    check("single_tvalid_c2", bus.m_axis_tvalid, 1);
    check("single_tdata_c2", bus.m_axis_tdata, word_t'(8'hA5));
    @(negedge clk);
    check("single_tvalid_c3", bus.m_axis_tvalid, 0);
    wait_drain(20);

    // Streaming 1..16 with tready held high
    at_tick();
    for (int i = 1; i <= 16; i++) load(word_t'(i));
    rd_first = -1; rd_last = -1; rd_cnt = 0;
    bt_first = -1; bt_last = -1; bt_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (bus.rd_en) begin
        if (rd_first < 0) rd_first = t;
        rd_last = t;
        rd_cnt++;
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        if (bt_first < 0) bt_first = t;
        bt_last = t;
        bt_cnt++;
      end
    end
    check("stream_rd_count", rd_cnt, 16);
    check("stream_rd_span", rd_last - rd_first, 15);
    check("stream_beat_count", bt_cnt, 16);
    check("stream_beat_span", bt_last - bt_first, 15);
    check("stream_latency", bt_first - rd_first, 2);
    wait_drain(20);

    // Backpressure: stream stalled while the FIFO holds 1..8
    at_tick();
    bus.m_axis_tready = 1'b0;
    for (int i = 1; i <= 8; i++) load(word_t'(i));
    @(negedge clk);
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 1) check("bp_rd_en_fill", bus.rd_en, 1);
      if (c >= 3) begin
        check("bp_level_full", bus.buf_level, 2);
        check("bp_rd_en_stalled", bus.rd_en, 0);
        check("bp_tdata_first", bus.m_axis_tdata, 1);
      end
    end
    at_tick();
    bus.m_axis_tready = 1'b1;
    wait_drain(40);

    // Reset while the buffer is full
    at_tick();
    bus.m_axis_tready = 1'b0;
    for (int i = 0; i < 8; i++) load(word_t'(8'h20 + i));
    n = 0;
    while (bus.buf_level != 2'd2 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rstmid_reached_full", bus.buf_level, 2);
    at_tick();
    rst = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    #1;
    check("rstmid_tvalid", bus.m_axis_tvalid, 0);
    check("rstmid_level", bus.buf_level, 0);
    check("rstmid_rd_en", bus.rd_en, 0);
    check("rstmid_tdata", bus.m_axis_tdata, 0);
    repeat (2) at_tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) load(word_t'(8'h10 + i));
    bus.m_axis_tready = 1'b1;
    wait_drain(40);

    // Random tready and empty gaps over 1000 words
    at_tick();
    gap_pct = 30;
    for (int i = 0; i < 1000; i++) load(rand_word());
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      at_tick();
      bus.m_axis_tready = 1'($urandom_range(1));
      n++;
    end
    check("random_drained", exp_q.size(), 0);
    gap_pct = 0;
    bus.m_axis_tready = 1'b1;
    repeat (5) at_tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
